alu_arbiter: RTL and testbench

Sequencing controller and two-port arbiter for the shared 4-bit ALU. Two requesters compete for the ALU through a req/gnt/done handshake. The block latches the winner's operands and opcode and drives them onto the ALU inputs. It waits a fixed number of cycles for the gate-level ALU (with its ns-scale gate delays) to settle, then captures result, overflow and zero into registers and returns them to the winner. Arbitration is round-robin. The ALU itself is instantiated beside this block, not inside it.

---
 rtl/alu_arbiter.sv | 138 +++++++++++++
 tb/tb_alu_arbiter.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/alu_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : alu_arbiter
// Description : Round-robin two-port arbiter and sequencer for a shared 4-bit
//               ALU. Latches the winner's operands, holds them for a fixed
//               settle time, captures the ALU outputs, and pulses done.
// Revision    : 1.0 - initial release
// ============================================================================
module alu_arbiter #(
  parameter int SETTLE_CYCLES = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       req0,
  input  logic       req1,
  input  logic [3:0] a0,
  input  logic [3:0] b0,
  input  logic [3:0] a1,
  input  logic [3:0] b1,
  input  logic [1:0] op0,
  input  logic [1:0] op1,
  output logic       gnt0,
  output logic       gnt1,
  output logic       done0,
  output logic       done1,
  output logic       busy,
  output logic [3:0] result,
  output logic       overflow,
  output logic       zero,
  output logic [3:0] alu_a,
  output logic [3:0] alu_b,
  output logic [1:0] alu_op,
  input  logic [3:0] alu_result,
  input  logic       alu_overflow,
  input  logic       alu_zero
);

  localparam logic [3:0] CNT_INIT = 4'(SETTLE_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t     state;
  state_t     state_nxt;
  logic [3:0] cnt;
  logic       winner;
  logic       last_served;

  // Strobes from the next-state logic that steer the datapath registers
  logic       start;
  logic       pick;
  logic       capture;
  logic       finish;

  // Next-state and strobe decode; a tie goes to whoever was not served last
  always_comb begin
    state_nxt = state;
    start     = 1'b0;
    pick      = winner;
    capture   = 1'b0;
    finish    = 1'b0;
    case (state)
      IDLE: begin
        if (req0 || req1) begin
          start     = 1'b1;
          pick      = (req0 && req1) ? ~last_served : req1;
          state_nxt = RUN;
        end
      end
      RUN: begin
        if (cnt == 4'd0) begin
          capture   = 1'b1;
          state_nxt = DONE;
        end
      end
      DONE: begin
        finish    = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // State, counter, operand latch, result capture and handshake registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= IDLE;
      cnt         <= 4'd0;
      winner      <= 1'b0;
      last_served <= 1'b1;
      gnt0        <= 1'b0;
      gnt1        <= 1'b0;
      done0       <= 1'b0;
      done1       <= 1'b0;
      result      <= 4'd0;
      overflow    <= 1'b0;
      zero        <= 1'b0;
      alu_a       <= 4'd0;
      alu_b       <= 4'd0;
      alu_op      <= 2'd0;
    end else begin
      state <= state_nxt;
      if (start) begin
        winner <= pick;
        alu_a  <= pick ? a1 : a0;
        alu_b  <= pick ? b1 : b0;
        alu_op <= pick ? op1 : op0;
        gnt0   <= ~pick;
        gnt1   <= pick;
        cnt    <= CNT_INIT;
      end else if (state == RUN && cnt != 4'd0) begin
        cnt <= cnt - 4'd1;
      end
      if (capture) begin
        result   <= alu_result;
        overflow <= alu_overflow;
        zero     <= alu_zero;
        done0    <= ~winner;
        done1    <= winner;
      end
      if (finish) begin
        done0       <= 1'b0;
        done1       <= 1'b0;
        gnt0        <= 1'b0;
        gnt1        <= 1'b0;
        last_served <= winner;
      end
    end
  end

  // Busy reflects any non-idle state directly
  assign busy = (state != IDLE);

endmodule
`default_nettype wire

// File: tb/tb_alu_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_alu_arbiter
// Description : Self-checking bench for alu_arbiter with a behavioural ALU
//               stand-in and an arithmetic reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_alu_arbiter;

  localparam int S = 4;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       req0, req1;
  logic [3:0] a0, b0, a1, b1;
  logic [1:0] op0, op1;
  logic       gnt0, gnt1, done0, done1, busy;
  logic [3:0] result;
  logic       overflow, zero;
  logic [3:0] alu_a, alu_b;
  logic [1:0] alu_op;
  logic [3:0] alu_result;
  logic       alu_overflow, alu_zero;

  int passed = 0;
  int total  = 0;
  bit last   = 1'b1;

  alu_arbiter #(.SETTLE_CYCLES(S)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0(req0), .req1(req1),
    .a0(a0), .b0(b0), .a1(a1), .b1(b1),
    .op0(op0), .op1(op1),
    .gnt0(gnt0), .gnt1(gnt1), .done0(done0), .done1(done1), .busy(busy),
    .result(result), .overflow(overflow), .zero(zero),
    .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op),
    .alu_result(alu_result), .alu_overflow(alu_overflow), .alu_zero(alu_zero)
  );

  always #5 clk = ~clk;

  // Stand-in for the external ALU: 00 add, 01 sub, 10 and, 11 xor
  always_comb begin
    alu_result   = 4'd0;
    alu_overflow = 1'b0;
    case (alu_op)
      2'b00: begin
        alu_result   = alu_a + alu_b;
        alu_overflow = (alu_a[3] == alu_b[3]) && (alu_result[3] != alu_a[3]);
      end
      2'b01: begin
        alu_result   = alu_a - alu_b;
        alu_overflow = (alu_a[3] != alu_b[3]) && (alu_result[3] != alu_a[3]);
      end
      2'b10:   alu_result = alu_a & alu_b;
      default: alu_result = alu_a ^ alu_b;
    endcase
    alu_zero = (alu_result == 4'd0);
  end

  task automatic check(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // Reference: signed integer arithmetic with range test for overflow
  function automatic void ref_alu(input logic [3:0] a, input logic [3:0] b,
                                  input logic [1:0] op, output logic [3:0] r,
                                  output logic v, output logic z);
    int sa, sb, t;
    sa = a[3] ? int'(a) - 16 : int'(a);
    sb = b[3] ? int'(b) - 16 : int'(b);
    case (op)
      2'd0:    t = sa + sb;
      2'd1:    t = sa - sb;
      2'd2:    t = int'(a & b);
      default: t = int'(a ^ b);
    endcase
    r = t[3:0];
    v = (op < 2'd2) && (t > 7 || t < -8);
    z = (r == 4'd0);
  endfunction

  // One full operation from an IDLE negedge to the IDLE negedge after DONE
  task automatic do_op(input bit disturb);
    bit w;
    logic [3:0] ea, eb, er;
    logic [1:0] eo;
    logic ev, ez;
    w  = (req0 && req1) ? ~last : req1;
    ea = w ? a1 : a0;
    eb = w ? b1 : b0;
    eo = w ? op1 : op0;
    ref_alu(ea, eb, eo, er, ev, ez);
    @(negedge clk);
    check("gnt0_e0", gnt0, !w);
    check("gnt1_e0", gnt1, w);
    check("busy_e0", busy, 1'b1);
    check("done_e0", {done1, done0}, 2'b00);
    check("alu_a_e0", alu_a, ea);
    check("alu_b_e0", alu_b, eb);
    check("alu_op_e0", alu_op, eo);
    if (disturb) begin
      a0 = 4'($urandom); b0 = 4'($urandom); op0 = 2'($urandom);
      a1 = 4'($urandom); b1 = 4'($urandom); op1 = 2'($urandom);
      req0 = 1'b0; req1 = 1'b0;
    end
    for (int k = 1; k < S; k++) begin
      @(negedge clk);
      check("gnt_run", {gnt1, gnt0}, {w, !w});
      check("done_run", {done1, done0}, 2'b00);
      check("busy_run", busy, 1'b1);
      check("alu_a_run", alu_a, ea);
      check("alu_op_run", alu_op, eo);
    end
    @(negedge clk);
    check("done_pulse", {done1, done0}, {w, !w});
    check("gnt_done", {gnt1, gnt0}, {w, !w});
    check("busy_done", busy, 1'b1);
    check("result", result, er);
    check("overflow", overflow, ev);
    check("zero", zero, ez);
    @(negedge clk);
    check("gnt_idle", {gnt1, gnt0}, 2'b00);
    check("done_idle", {done1, done0}, 2'b00);
    check("busy_idle", busy, 1'b0);
    check("result_hold", result, er);
    last = w;
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_gnt"}, {gnt1, gnt0}, 2'b00);
    check({tag, "_done"}, {done1, done0}, 2'b00);
    check({tag, "_busy"}, busy, 1'b0);
    check({tag, "_result"}, result, 4'd0);
    check({tag, "_flags"}, {overflow, zero}, 2'b00);
    check({tag, "_alu_a"}, alu_a, 4'd0);
    check({tag, "_alu_b"}, alu_b, 4'd0);
    check({tag, "_alu_op"}, alu_op, 2'd0);
  endtask

  initial begin
    rst_n = 1'b0; req0 = 1'b0; req1 = 1'b0;
    a0 = 4'd0; b0 = 4'd0; a1 = 4'd0; b1 = 4'd0; op0 = 2'd0; op1 = 2'd0;
    repeat (2) @(negedge clk);
    check_reset_vals("reset");
    rst_n = 1'b1;
    @(negedge clk);

    // Add 3+4 by requester 0
    req0 = 1'b1; a0 = 4'b0011; b0 = 4'b0100; op0 = 2'b00;
    do_op(1'b0);
    check("add_result", result, 4'b0111);
    req0 = 1'b0;

    // Subtract to zero by requester 1
    req1 = 1'b1; a1 = 4'b0101; b1 = 4'b0101; op1 = 2'b01;
    do_op(1'b0);
    check("sub_zero", zero, 1'b1);
    req1 = 1'b0;

    // Signed overflow 7+1
    req0 = 1'b1; a0 = 4'b0111; b0 = 4'b0001; op0 = 2'b00;
    do_op(1'b0);
    check("ovf_flag", overflow, 1'b1);
    req0 = 1'b0;
    @(negedge clk);

    // Operands and request change during RUN must not matter
    req0 = 1'b1; a0 = 4'b0010; b0 = 4'b0001; op0 = 2'b00;
    do_op(1'b1);
    check("midrun_result", result, 4'b0011);

    // Reset at edge 2 of an operation
    req0 = 1'b1; req1 = 1'b0; a0 = 4'b0111; b0 = 4'b0001; op0 = 2'b00;
    @(negedge clk);
    check("pre_rst_gnt0", gnt0, 1'b1);
    @(negedge clk);
    rst_n = 1'b0; req0 = 1'b0;
    @(negedge clk);
    check_reset_vals("midrun_rst");
    rst_n = 1'b1;
    last  = 1'b1;
    for (int k = 0; k < S + 2; k++) begin
      @(negedge clk);
      check("no_done_after_rst", {done1, done0, busy}, 3'b000);
    end

    // Continuous dual requests after reset alternate 0,1,0,1
    req0 = 1'b1; req1 = 1'b1;
    for (int i = 0; i < 4; i++) begin
      a0 = 4'($urandom); b0 = 4'($urandom); op0 = 2'($urandom);
      a1 = 4'($urandom); b1 = 4'($urandom); op1 = 2'($urandom);
      do_op(1'b0);
      check("tie_order", {1'b0, last}, {1'b0, 1'(i % 2)});
    end
    req0 = 1'b0; req1 = 1'b0;

    // Randomised operations against the reference model
    for (int i = 0; i < 24; i++) begin
      int pat;
      pat = int'($urandom_range(1, 3));
      req0 = pat[0]; req1 = pat[1];
      a0 = 4'($urandom); b0 = 4'($urandom); op0 = 2'($urandom);
      a1 = 4'($urandom); b1 = 4'($urandom); op1 = 2'($urandom);
      do_op(1'($urandom));
      req0 = 1'b0; req1 = 1'b0;
      if ($urandom_range(0, 1) == 1) @(negedge clk);
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
`default_nettype wire
